// File: rtl/conv_drain_pkg.sv
// Shared types and default sizes for the encoder sub-block drain.
package conv_drain_pkg;

  localparam int unsigned BYTE_W          = 8;
  localparam int unsigned CNT_W           = 10;
  localparam int unsigned DEF_SMALL_BYTES = 132;
  localparam int unsigned DEF_LARGE_BYTES = 768;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_READ  = 3'd1,
    ST_LOAD  = 3'd2,
    ST_SEND0 = 3'd3,
    ST_SEND1 = 3'd4,
    ST_SEND2 = 3'd5
  } drain_state_e;

  // One byte index worth of data, one byte per stream.
  typedef struct packed {
    logic [BYTE_W-1:0] s2;
    logic [BYTE_W-1:0] s1;
    logic [BYTE_W-1:0] s0;
  } drain_group_t;

endpackage

// File: rtl/drain_byte_counter.sv
// Byte-index counter for one drained block; flags the final byte of the
// selected block length and saturates there so it cannot wrap.
module drain_byte_counter
  import conv_drain_pkg::*;
#(
  parameter int unsigned SMALL_BYTES = DEF_SMALL_BYTES,
  parameter int unsigned LARGE_BYTES = DEF_LARGE_BYTES
) (
  input  logic clk,
  input  logic reset,
  input  logic clr,
  input  logic en,
  input  logic len_sel,
  output logic last_c
);

  logic [CNT_W-1:0] count;
  logic [CNT_W-1:0] final_idx;

  assign final_idx = len_sel ? CNT_W'(LARGE_BYTES - 1) : CNT_W'(SMALL_BYTES - 1);
  assign last_c    = (count == final_idx);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      count <= '0;
    end else if (clr) begin
      count <= '0;
    end else if (en && !last_c) begin
      count <= count + CNT_W'(1);
    end
  end

endmodule

// File: rtl/subblock_drain.sv
// Drains the encoder's three output FIFOs one byte index at a time and
// serializes them d0,d1,d2 onto a valid/ready byte stream. Optional macro
// STREAM_TAG_EN adds the out_sel stream-tag output.
module subblock_drain
  import conv_drain_pkg::*;
#(
  parameter int unsigned SMALL_BYTES = DEF_SMALL_BYTES,
  parameter int unsigned LARGE_BYTES = DEF_LARGE_BYTES
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              computation_done,
  input  logic              length_in,
  input  logic              fifo_empty,
  input  logic [BYTE_W-1:0] q0,
  input  logic [BYTE_W-1:0] q1,
  input  logic [BYTE_W-1:0] q2,
  output logic              rdreq_subblock,
  output logic [BYTE_W-1:0] out_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic              out_last,
  output logic              busy,
`ifdef STREAM_TAG_EN
  output logic [1:0]        out_sel,
`endif
  output logic              err
);

  drain_state_e      state_q, state_d;
  drain_group_t      hold_q;
  logic              len_r;
  logic              handshake;
  logic              last_c;
  logic              cnt_clr, cnt_en, len_load, hold_load;
  logic              err_d, out_valid_d, out_last_d;
  logic [BYTE_W-1:0] out_data_d;

  assign handshake = out_valid & out_ready;

  drain_byte_counter #(
    .SMALL_BYTES (SMALL_BYTES),
    .LARGE_BYTES (LARGE_BYTES)
  ) u_cnt (
    .clk     (clk),
    .reset   (reset),
    .clr     (cnt_clr),
    .en      (cnt_en),
    .len_sel (len_r),
    .last_c  (last_c)
  );

  // Next state plus next values for the registered outputs.
  always_comb begin
    state_d        = state_q;
    rdreq_subblock = 1'b0;
    cnt_clr        = 1'b0;
    cnt_en         = 1'b0;
    len_load       = 1'b0;
    hold_load      = 1'b0;
    err_d          = err;
    out_valid_d    = 1'b0;
    out_data_d     = '0;
    out_last_d     = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (computation_done) begin
          len_load = 1'b1;
          cnt_clr  = 1'b1;
          err_d    = 1'b0;
          state_d  = ST_READ;
        end
      end
      ST_READ: begin
        if (!fifo_empty) begin
          rdreq_subblock = 1'b1;
          state_d        = ST_LOAD;
        end else begin
          err_d   = 1'b1;
          state_d = ST_IDLE;
        end
      end
      ST_LOAD: begin
        hold_load   = 1'b1;
        out_valid_d = 1'b1;
        out_data_d  = q0;
        state_d     = ST_SEND0;
      end
      ST_SEND0: begin
        out_valid_d = 1'b1;
        if (handshake) begin
          out_data_d = hold_q.s1;
          state_d    = ST_SEND1;
        end else begin
          out_data_d = hold_q.s0;
        end
      end
      ST_SEND1: begin
        out_valid_d = 1'b1;
        if (handshake) begin
          out_data_d = hold_q.s2;
          out_last_d = last_c;
          state_d    = ST_SEND2;
        end else begin
          out_data_d = hold_q.s1;
        end
      end
      ST_SEND2: begin
        if (handshake) begin
          cnt_en  = 1'b1;
          state_d = last_c ? ST_IDLE : ST_READ;
        end else begin
          out_valid_d = 1'b1;
          out_data_d  = hold_q.s2;
          out_last_d  = last_c;
        end
      end
      default: state_d = ST_IDLE;
    endcase
    // A new block announced mid-drain is dropped and flagged.
    if (computation_done && (state_q != ST_IDLE)) begin
      err_d = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q   <= ST_IDLE;
      len_r     <= 1'b0;
      hold_q    <= '0;
      out_valid <= 1'b0;
      out_data  <= '0;
      out_last  <= 1'b0;
      busy      <= 1'b0;
      err       <= 1'b0;
    end else begin
      state_q   <= state_d;
      if (len_load) begin
        len_r <= length_in;
      end
      if (hold_load) begin
        hold_q <= {q2, q1, q0};
      end
      out_valid <= out_valid_d;
      out_data  <= out_data_d;
      out_last  <= out_last_d;
      busy      <= (state_d != ST_IDLE);
      err       <= err_d;
    end
  end

`ifdef STREAM_TAG_EN
  // Stream tag follows the SEND state being entered.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      out_sel <= 2'd0;
    end else begin
      case (state_d)
        ST_SEND1: out_sel <= 2'd1;
        ST_SEND2: out_sel <= 2'd2;
        default:  out_sel <= 2'd0;
      endcase
    end
  end
`endif

endmodule

// File: tb/tb_subblock_drain.sv
// Randomized bench for subblock_drain: FIFO queues feed the DUT and a
// block-level reference list of expected bytes is checked beat by beat.
module tb_subblock_drain;

  localparam int SB = 132;
  localparam int LB = 768;

  logic       clk              = 1'b0;
  logic       reset            = 1'b0;
  logic       computation_done = 1'b0;
  logic       length_in        = 1'b0;
  logic       fifo_empty       = 1'b1;
  logic       out_ready        = 1'b0;
  logic [7:0] q0 = '0, q1 = '0, q2 = '0;
  logic       rdreq_subblock, out_valid, out_last, busy, err;
  logic [7:0] out_data;
`ifdef STREAM_TAG_EN
  logic [1:0] out_sel;
`endif

  int n_checks = 0;
  int n_fail   = 0;
  logic [7:0] f0[$], f1[$], f2[$];

  always #5 clk = ~clk;

  subblock_drain #(.SMALL_BYTES(SB), .LARGE_BYTES(LB)) dut (
    .clk              (clk),
    .reset            (reset),
    .computation_done (computation_done),
    .length_in        (length_in),
    .fifo_empty       (fifo_empty),
    .q0               (q0),
    .q1               (q1),
    .q2               (q2),
    .rdreq_subblock   (rdreq_subblock),
    .out_data         (out_data),
    .out_valid        (out_valid),
    .out_ready        (out_ready),
    .out_last         (out_last),
    .busy             (busy),
`ifdef STREAM_TAG_EN
    .out_sel          (out_sel),
`endif
    .err              (err)
  );

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h want=%0h t=%0t", tag, act, exp, $time);
    end
  endtask

  task automatic check_zero(input string tag);
    check({tag, "_valid"}, 32'(out_valid), 0);
    check({tag, "_data"},  32'(out_data), 0);
    check({tag, "_last"},  32'(out_last), 0);
    check({tag, "_busy"},  32'(busy), 0);
    check({tag, "_err"},   32'(err), 0);
    check({tag, "_rdreq"}, 32'(rdreq_subblock), 0);
`ifdef STREAM_TAG_EN
    check({tag, "_sel"},   32'(out_sel), 0);
`endif
  endtask

  // mode: 0 = ready always high, 1 = random ready, 2 = 4-cycle stall on beat 10
  task automatic run_block(input bit len, input int loaded, input int mode,
                           input bit extra_done, input int abort_beat);
    int   nb, ngrp, beats, rdreqs, cyc, first_valid, stall, budget;
    bit   exp_err, hold, pop, aborted;
    logic [7:0] e[$];
    bit   el[$];
    nb          = len ? LB : SB;
    ngrp        = (loaded < nb) ? loaded : nb;
    exp_err     = (loaded < nb) || extra_done;
    beats       = 0;
    rdreqs      = 0;
    cyc         = 0;
    first_valid = -1;
    stall       = 0;
    hold        = 1'b0;
    pop         = 1'b0;
    aborted     = 1'b0;
    budget      = 12 * nb + 100;
    f0.delete(); f1.delete(); f2.delete();
    for (int i = 0; i < loaded; i++) begin
      f0.push_back(8'($urandom));
      f1.push_back(8'($urandom));
      f2.push_back(8'($urandom));
    end
    if (mode == 2) f1[3] = 8'hA5;
    for (int i = 0; i < ngrp; i++) begin
      e.push_back(f0[i]); el.push_back(1'b0);
      e.push_back(f1[i]); el.push_back(1'b0);
      e.push_back(f2[i]); el.push_back((loaded >= nb) && (i == nb - 1));
    end

    @(negedge clk);
    computation_done = 1'b1;
    length_in        = len;
    fifo_empty       = (f0.size() == 0);
    out_ready        = 1'b1;
    @(posedge clk); #1;
    computation_done = 1'b0;

    while (1) begin
      @(negedge clk);
      cyc++;
      fifo_empty       = (f0.size() == 0);
      length_in        = ~len;
      computation_done = extra_done && (cyc == 20);
      case (mode)
        1: out_ready = ($urandom_range(0, 3) != 0);
        2: begin
          if (out_valid && beats == 10 && stall < 4) begin
            out_ready = 1'b0;
            stall++;
          end else begin
            out_ready = 1'b1;
          end
        end
        default: out_ready = 1'b1;
      endcase
      #1;
      if (abort_beat >= 0 && out_valid && beats == abort_beat) begin
        reset = 1'b0;
        #1;
        check_zero("abort");
        aborted = 1'b1;
        computation_done = 1'b0;
        f0.delete(); f1.delete(); f2.delete();
        q0 = '0; q1 = '0; q2 = '0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        check_zero("abort_hold");
        reset = 1'b1;
        break;
      end
      if (out_valid && first_valid < 0) begin
        first_valid = cyc;
        check("latency", 32'(cyc), 3);
      end
      if (hold) check("hold_valid", 32'(out_valid), 1);
      if (out_valid) begin
        if (beats < e.size()) begin
          check("data", 32'(out_data), 32'(e[beats]));
          check("last", 32'(out_last), 32'(el[beats]));
        end else begin
          check("extra_beat", 32'(beats), 32'(e.size()));
        end
`ifdef STREAM_TAG_EN
        check("sel", 32'(out_sel), 32'(beats % 3));
`endif
        check("rdreq_in_send", 32'(rdreq_subblock), 0);
        if (out_ready) beats++;
      end else begin
        check("last_idle", 32'(out_last), 0);
`ifdef STREAM_TAG_EN
        check("sel_idle", 32'(out_sel), 0);
`endif
      end
      if (rdreq_subblock) begin
        check("rdreq_empty", 32'(fifo_empty), 0);
        rdreqs++;
      end
      pop  = rdreq_subblock && (f0.size() != 0);
      hold = out_valid && !out_ready;
      if (!busy) break;
      if (cyc >= budget) begin
        check("timeout_busy", 32'(busy), 0);
        break;
      end
      @(posedge clk); #1;
      if (pop) begin
        q0 = f0.pop_front();
        q1 = f1.pop_front();
        q2 = f2.pop_front();
      end
    end
    computation_done = 1'b0;

    if (abort_beat >= 0) begin
      check("abort_reached", 32'(aborted), 1);
    end else begin
      check("beats", 32'(beats), 32'(3 * ngrp));
      check("rdreqs", 32'(rdreqs), 32'(ngrp));
      check("err_end", 32'(err), 32'(exp_err));
      check("valid_end", 32'(out_valid), 0);
      if (mode == 0 && loaded >= nb && !extra_done)
        check("cycles", 32'(cyc), 32'(5 * ngrp + 1));
    end
  endtask

  initial begin
    repeat (3) @(negedge clk);
    computation_done = 1'b1;
    fifo_empty       = 1'b0;
    #1;
    check_zero("reset");
    @(negedge clk);
    check_zero("reset2");
    computation_done = 1'b0;
    fifo_empty       = 1'b1;
    reset            = 1'b1;
    @(negedge clk);
    check_zero("idle");

    run_block(1'b0, SB, 0, 1'b0, -1);   // short block, free-running
    run_block(1'b1, LB, 0, 1'b0, -1);   // long block, free-running
    run_block(1'b0, SB, 1, 1'b0, -1);   // random backpressure
    run_block(1'b0, SB, 2, 1'b0, -1);   // directed stall on 0xA5
    run_block(1'b0, 10, 1, 1'b0, -1);   // underflow after 10 bytes
    run_block(1'b0, SB, 0, 1'b0, -1);   // err cleared by next block
    run_block(1'b0, SB, 1, 1'b1, -1);   // done while busy
    run_block(1'b0, SB, 1, 1'b0, 152);  // reset in SEND2 of byte 50
    run_block(1'b0, SB, 0, 1'b0, -1);   // clean block after reset
    run_block(1'b1, LB, 1, 1'b0, -1);   // long block, random backpressure

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
